mul_hilo_ctrl: RTL and testbench

- Control and writeback stage wrapped around the sequential shift-add multiplier in the datapath.
- Accepts a MUL request from the control unit and latches the operands.
- Launches the multiplier, then waits for completion with a bounded cycle counter.
- Captures the 64-bit product into the HI/LO registers and signals completion.
- Holds `busy` high while a multiply is outstanding so the control unit stalls.

---
 rtl/mul_hilo_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl.sv
// ----------------------------------------------------------------------------
// mul_hilo_ctrl
//   Control and writeback stage around the sequential shift-add multiplier.
//   A MUL request is accepted in IDLE. The operands are latched and the
//   multiplier is launched. The stage then waits for the completion strobe,
//   bounded by TIMEOUT cycles. The product is written into HI/LO, and done
//   pulses for one cycle. busy stays high while a multiply is outstanding so
//   the control unit stalls.
//
// Parameters
//   WIDTH    operand width; the product is 2*WIDTH bits
//   TIMEOUT  maximum cycles spent in WAIT before aborting (>= WIDTH+2)
//   CNT_W    wait counter width (2**CNT_W > TIMEOUT)
//
// Ports
//   clk, rst     rising-edge clock; synchronous active-high reset
//   start        request pulse, sampled only in IDLE
//   op_a, op_b   operands, captured when start is accepted
//   busy         high in every state except IDLE
//   done         one-cycle pulse in the CAPTURE cycle
//   err          sticky timeout flag, cleared by rst or the next accepted start
//   mul_start    one-cycle launch pulse to the multiplier
//   mul_a, mul_b registered operands driven to the multiplier
//   mul_done     completion strobe from the multiplier
//   mul_product  product, valid while mul_done is high
//   hi_out       HI register, upper half of the product
//   lo_out       LO register, lower half of the product
//
// Build option
//   SIGNED_MUL_EN  two's-complement operands. mul_a and mul_b carry the
//                  magnitudes of the operands. The product is negated when
//                  the operand signs differ.
// ----------------------------------------------------------------------------
module mul_hilo_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic [WIDTH-1:0]   hi_out,
    output logic [WIDTH-1:0]   lo_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] result;

`ifdef SIGNED_MUL_EN
    logic               neg_q, neg_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        err_d     = err_q;
        capture_d = capture_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result    = capture_q;
`ifdef SIGNED_MUL_EN
        neg_d     = neg_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef SIGNED_MUL_EN
                    // The most-negative value negates to itself. Read as
                    // unsigned, it is the correct magnitude.
                    mul_a_d = op_a[WIDTH-1] ? -op_a : op_a;
                    mul_b_d = op_b[WIDTH-1] ? -op_b : op_b;
                    neg_d   = op_a[WIDTH-1] ^ op_b[WIDTH-1];
`else
                    mul_a_d = op_a;
                    mul_b_d = op_b;
`endif
                    err_d   = 1'b0;
                    state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the final timeout cycle still counts as a
                // completion.
                if (mul_done) begin
                    capture_d = mul_product;
                    state_d   = S_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_CAPTURE: begin
`ifdef SIGNED_MUL_EN
                if (neg_q) begin
                    result = -capture_q;
                end
`endif
                hi_d    = result[2*WIDTH-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            err_q     <= 1'b0;
            capture_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef SIGNED_MUL_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            err_q     <= err_d;
            capture_q <= capture_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef SIGNED_MUL_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_CAPTURE);
    assign mul_start = (state_q == S_LAUNCH);
    assign err       = err_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_hilo_ctrl
//   Directed bench for mul_hilo_ctrl. The bench plays the multiplier: it
//   asserts mul_done in a chosen WAIT cycle, or never. Expected results are
//   hand-computed constants. Build with SIGNED_MUL_EN defined to run the
//   signed vectors.
// ----------------------------------------------------------------------------
module tb_mul_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done, err, mul_start;
    logic [31:0] mul_a, mul_b;
    logic        mul_done;
    logic [63:0] mul_product;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_errors = 0;

    mul_hilo_ctrl #(
        .WIDTH   (32),
        .TIMEOUT (40),
        .CNT_W   (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then act as the multiplier until busy falls.
    // Cycle c=0 is the first cycle after acceptance (LAUNCH). mul_done is
    // raised in cycle n_wait+1, which is the (n_wait+1)-th WAIT cycle.
    // n_wait < 0 means mul_done is never raised.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input int n_wait, input bit poke,
                         output int busy_cnt, output int done_cnt, output int done_at,
                         output int ms_cnt, output int ms_at,
                         output logic [31:0] a_l, output logic [31:0] b_l,
                         output bit stable, output logic err_l);
        busy_cnt = 0; done_cnt = 0; done_at = -1; ms_cnt = 0; ms_at = -1;
        a_l = '0; b_l = '0; stable = 1'b1; err_l = 1'b1;
        start = 1'b1; op_a = a; op_b = b;
        tick;
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            busy_cnt++;
            if (done) begin done_cnt++; done_at = c; end
            if (mul_start) begin ms_cnt++; ms_at = c; end
            if (c == 0) begin
                a_l = mul_a; b_l = mul_b; err_l = err;
            end else if (mul_a !== a_l || mul_b !== b_l) begin
                stable = 1'b0;
            end
            if (poke && c == 5) begin
                start = 1'b1; op_a = ~a; op_b = ~b;
            end else begin
                start = 1'b0;
            end
            mul_done    = (n_wait >= 0) && (c == n_wait + 1);
            mul_product = mul_done ? ({32'b0, mul_a} * {32'b0, mul_b}) : 64'hDEAD_BEEF_0BAD_F00D;
            tick;
        end
        mul_done = 1'b0;
        start    = 1'b0;
        check_eq("op_returns_idle", 64'(busy), 64'd0);
    endtask

    int          bc, dc, da, mc, ma;
    logic [31:0] al, bl;
    bit          st;
    logic        el;
    bit          done_seen;

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        mul_done = 1'b0; mul_product = '0;
        tick; tick;
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_done",      64'(done),      64'd0);
        check_eq("rst_err",       64'(err),       64'd0);
        check_eq("rst_mul_start", 64'(mul_start), 64'd0);
        check_eq("rst_mul_a",     64'(mul_a),     64'd0);
        check_eq("rst_mul_b",     64'(mul_b),     64'd0);
        check_eq("rst_hi",        64'(hi_out),    64'd0);
        check_eq("rst_lo",        64'(lo_out),    64'd0);
        rst = 1'b0;
        tick;

        // Unsigned basic. Product after 32 WAIT cycles; a start during busy is ignored.
        do_op(32'h0000_FFFF, 32'h0001_0000, 32, 1'b1, bc, dc, da, mc, ma, al, bl, st, el);
        check_eq("basic_busy_cycles", 64'(bc), 64'd35);
        check_eq("basic_done_count",  64'(dc), 64'd1);
        check_eq("basic_done_at",     64'(da), 64'd34);
        check_eq("basic_ms_count",    64'(mc), 64'd1);
        check_eq("basic_ms_at",       64'(ma), 64'd0);
        check_eq("basic_mul_a",       64'(al), 64'h0000_FFFF);
        check_eq("basic_mul_b",       64'(bl), 64'h0001_0000);
        check_eq("basic_ops_stable",  64'(st), 64'd1);
        check_eq("basic_hi",          64'(hi_out), 64'h0000_0000);
        check_eq("basic_lo",          64'(lo_out), 64'hFFFF_0000);
        check_eq("basic_err",         64'(err),    64'd0);

        // Back-to-back: this start lands in the cycle right after done.
        do_op(32'h89AB_CDEF, 32'h0001_0000, 3, 1'b0, bc, dc, da, mc, ma, al, bl, st, el);
        check_eq("b2b_ms_count",    64'(mc), 64'd1);
        check_eq("b2b_ms_at",       64'(ma), 64'd0);
        check_eq("b2b_busy_cycles", 64'(bc), 64'd6);
        check_eq("b2b_hi",          64'(hi_out), 64'h0000_89AB);
        check_eq("b2b_lo",          64'(lo_out), 64'hCDEF_0000);

        // Timeout: mul_done never comes, so WAIT lasts 40 cycles (counter 0..39).
        do_op(32'd2, 32'd3, -1, 1'b0, bc, dc, da, mc, ma, al, bl, st, el);
        check_eq("to_busy_cycles", 64'(bc), 64'd41);
        check_eq("to_done_count",  64'(dc), 64'd0);
        check_eq("to_err",         64'(err), 64'd1);
        check_eq("to_hi_hold",     64'(hi_out), 64'h0000_89AB);
        check_eq("to_lo_hold",     64'(lo_out), 64'hCDEF_0000);

        // mul_done in the last timeout cycle wins. The accept also clears err.
        do_op(32'd3, 32'd5, 39, 1'b0, bc, dc, da, mc, ma, al, bl, st, el);
        check_eq("edge_err_cleared", 64'(el), 64'd0);
        check_eq("edge_done_count",  64'(dc), 64'd1);
        check_eq("edge_done_at",     64'(da), 64'd41);
        check_eq("edge_err",         64'(err), 64'd0);
        check_eq("edge_hi",          64'(hi_out), 64'h0000_0000);
        check_eq("edge_lo",          64'(lo_out), 64'h0000_000F);

`ifdef SIGNED_MUL_EN
        do_op(32'hFFFF_FFFD, 32'd7, 5, 1'b0, bc, dc, da, mc, ma, al, bl, st, el);
        check_eq("sgn_mul_a", 64'(al), 64'd3);
        check_eq("sgn_mul_b", 64'(bl), 64'd7);
        check_eq("sgn_hi",    64'(hi_out), 64'hFFFF_FFFF);
        check_eq("sgn_lo",    64'(lo_out), 64'hFFFF_FFEB);
        do_op(32'h8000_0000, 32'h8000_0000, 5, 1'b0, bc, dc, da, mc, ma, al, bl, st, el);
        check_eq("sgn_min_mul_a", 64'(al), 64'h8000_0000);
        check_eq("sgn_min_hi",    64'(hi_out), 64'h4000_0000);
        check_eq("sgn_min_lo",    64'(lo_out), 64'h0000_0000);
`else
        do_op(32'hFFFF_FFFD, 32'd7, 5, 1'b0, bc, dc, da, mc, ma, al, bl, st, el);
        check_eq("uns_mul_a", 64'(al), 64'hFFFF_FFFD);
        check_eq("uns_hi",    64'(hi_out), 64'h0000_0006);
        check_eq("uns_lo",    64'(lo_out), 64'hFFFF_FFEB);
`endif

        // Reset mid-WAIT, then a late mul_done that must be ignored.
        start = 1'b1; op_a = 32'd5; op_b = 32'd7;
        tick;
        start = 1'b0;
        tick; tick; tick;
        check_eq("midrst_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_eq("midrst_busy",  64'(busy),   64'd0);
        check_eq("midrst_mul_a", 64'(mul_a),  64'd0);
        check_eq("midrst_mul_b", 64'(mul_b),  64'd0);
        check_eq("midrst_hi",    64'(hi_out), 64'd0);
        check_eq("midrst_lo",    64'(lo_out), 64'd0);
        done_seen = 1'b0;
        mul_done = 1'b1; mul_product = 64'd35;
        tick;
        mul_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            done_seen |= done;
            tick;
        end
        check_eq("midrst_no_done",   64'(done_seen), 64'd0);
        check_eq("midrst_busy_late", 64'(busy),      64'd0);
        check_eq("midrst_lo_late",   64'(lo_out),    64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
